// File: rtl/div_mon_pkg.sv
// Shared types for the divided-clock monitor: FSM state codes and error-counter width.
package div_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } mon_state_e;

    localparam int unsigned ERR_W = 8;

endpackage

// File: rtl/sync_rise_det.sv
// Three-flop synchronizer for an asynchronous level with a one-cycle rising-edge pulse.
module sync_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures the divided-clock period in clk cycles and reports lock, sticky fault and error count.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int unsigned DIV      = 3,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_in,
    input  logic             clear_fault,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              fault_q, fault_d;
    logic              locked_q, locked_d;
    logic              pv_q, pv_d;

    logic             rise;
    logic             stall;
    logic             match;
    logic [CNT_W-1:0] meas;
    logic [ERR_W-1:0] err_inc;

    sync_rise_det u_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (div_in),
        .rise_o (rise)
    );

    assign meas    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign stall   = (meas == CNT_W'(TIMEOUT)) && !rise;
    assign match   = (meas == CNT_W'(DIV));
    assign err_inc = (&err_q) ? err_q : err_q + ERR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            err_q    <= '0;
            good_q   <= '0;
            fault_q  <= 1'b0;
            locked_q <= 1'b0;
            pv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            err_q    <= err_d;
            good_q   <= good_d;
            fault_q  <= fault_d;
            locked_q <= locked_d;
            pv_q     <= pv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        err_d    = err_q;
        good_d   = good_q;
        fault_d  = fault_q;
        locked_d = locked_q;
        pv_d     = 1'b0;
        cnt_d    = (state_q == ST_IDLE || rise) ? '0 : meas;

        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            good_d   = '0;
            fault_d  = 1'b0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise) state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d = meas;
                        pv_d     = 1'b1;
                        if (!match) begin
                            good_d = '0;
                            err_d  = err_inc;
                        end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            good_d   = GOOD_W'(LOCK_CNT);
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else if (stall) begin
                        good_d  = '0;
                        err_d   = err_inc;
                        state_d = ST_ARM;
                    end
                end
                ST_LOCKED: begin
                    // FAULT shares the LOCKED code; fault_q distinguishes the two.
                    if (fault_q) begin
                        if (clear_fault) begin
                            state_d = ST_ARM;
                            fault_d = 1'b0;
                            good_d  = '0;
                        end else if (rise) begin
                            period_d = meas;
                            pv_d     = 1'b1;
                        end
                    end else if (rise) begin
                        period_d = meas;
                        pv_d     = 1'b1;
                        if (!match) begin
                            fault_d  = 1'b1;
                            locked_d = 1'b0;
                            err_d    = err_inc;
                        end
                    end else if (stall) begin
                        fault_d  = 1'b1;
                        locked_d = 1'b0;
                        err_d    = err_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state        = state_q;
        locked       = locked_q;
        fault        = fault_q;
        period       = period_q;
        period_valid = pv_q;
        err_cnt      = err_q;
    end

endmodule
